fft_tw_mul8: RTL and testbench
==============================

Name: fft_tw_mul8

Overview:
- Consumer side of the 8-entry twiddle ROM interface: drives the 3-bit ROM address and reads back the 10-bit re/im twiddle pair.
- Multiplies each streamed complex sample by its twiddle and emits a rounded, saturated product.
- Sits between an FFT butterfly stage and the next stage.
- ROM is external and purely combinational: tw_re/tw_im are valid in the same cycle as tw_addr.

Parameters:
- DATA_W, 16, signed width of sample re/im in and out.
- TW_W, 10, signed twiddle width, two's complement, Q1.8 (256 = +1.0).
- TW_FRAC, 8, twiddle fractional bits; right-shift applied to the product.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- din_valid  in  1  sample present this cycle.
- din_start  in  1  first sample of an 8-sample block; qualified by din_valid.
- din_re  in  DATA_W  sample real part.
- din_im  in  DATA_W  sample imaginary part.
- tw_addr  out  3  twiddle ROM address.
- tw_re  in  TW_W  ROM real output.
- tw_im  in  TW_W  ROM imaginary output.
- dout_valid  out  1  product valid.
- dout_last  out  1  product is index 7 of its block.
- dout_idx  out  3  block index of the product.
- dout_re  out  DATA_W  product real part.
- dout_im  out  DATA_W  product imaginary part.
- restart_cnt  out  8  saturating count of blocks restarted before index 7.

Behaviour:
- Reset (rstn low, asynchronous):
  - Index counter = 0, both pipeline valid bits = 0.
  - All outputs = 0: dout_*, restart_cnt, and tw_addr.
  - Reset mid-block discards in-flight samples; no dout_valid appears for them after release.
- Index selection: cur_idx = 0 if (din_valid && din_start), else the counter value.
  - tw_addr = cur_idx, combinationally.
- Counter update:
  - On din_valid, counter <= cur_idx + 1 modulo 8, so it wraps 7 -> 0.
  - No din_valid: counter holds.
  - din_start with din_valid low: ignored.
- Restart count: when din_valid && din_start and the counter is not 0, restart_cnt increments, saturating at 255.
- No backpressure: a sample is accepted every cycle din_valid is high.
- Stage 1, registered on din_valid. Captures the four full-width products (DATA_W+TW_W bits each) and cur_idx:
  - din_re*tw_re, din_im*tw_im, din_re*tw_im, din_im*tw_re.
- Stage 2:
  - re_full = p_rr - p_ii; im_full = p_ri + p_ir, each computed at DATA_W+TW_W+1 bits.
  - Add 2^(TW_FRAC-1), then arithmetic right shift by TW_FRAC (round half up).
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Output registers: dout_re, dout_im, dout_idx, dout_last (= idx==7), dout_valid.
- Latency: a sample accepted at edge N (sampled with din_valid at edge N) appears with dout_valid at edge N+2. Throughput is 1 sample/cycle.
- Output hold:
  - dout_valid is a 1-cycle pulse per sample.
  - dout_re/im/idx/last hold their last value while dout_valid = 0.
- Gapped input: valid gaps pass through unchanged, and the index does not advance during gaps.

Decomposition:
- Shared package fft_pkg holds:
  - TW_W, TW_FRAC, TW_ONE (=256) constants.
  - typedef tw_t (signed TW_W).
  - typedef cplx_t struct {re, im} parameterised on DATA_W.
  - Saturate/round function sat_rnd.
- One sub-module: fft_cmul, the 2-stage pipelined complex multiplier with round/saturate.
- fft_tw_mul8 keeps the index counter, address drive, restart counter and valid/idx/last pipeline.

Test Plan:
- Reset, then 8 consecutive valid samples din=(1000,-500), din_start on the first, ROM model returns (256,0) for all addresses -> tw_addr 0..7 in order; 8 outputs equal (1000,-500); dout_idx 0..7; dout_last only on the 8th; first dout_valid 2 cycles after first accept.
- din=(300,200), tw=(0,-256) -> dout=(200,-300). din=(100,0), tw=(181,-181) -> dout=(71,-71) (70.7 rounds to 71, -70.7 rounds to -71).
- Saturation: din=(-32768,0), tw=(-256,0) -> dout_re=32767, dout_im=0. din=(32767,32767), tw=(256,256) -> dout=(0,32767).
- Gaps and wrap: valid pattern 1,0,0,1,1 over three blocks without din_start after the first -> index advances only on valid, wraps 7->0; restart_cnt stays 0.
- Early restart: din_start asserted with the 5th sample -> tw_addr=0 that cycle, dout_idx=0 for it, restart_cnt=1; din_start with din_valid=0 -> no effect.
- Async reset asserted mid-block with two samples in the pipeline -> outputs and restart_cnt clear immediately; no dout_valid after release until new input; next sample gets index 0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared fixed-point definitions for the FFT twiddle path.
// Holds the twiddle format, a complex sample type and the round/saturate helper.
package fft_pkg;

    localparam int DATA_W  = 16;
    localparam int TW_W    = 10;
    localparam int TW_FRAC = 8;
    localparam int TW_ONE  = 256;

    typedef logic signed [TW_W-1:0] tw_t;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_t;

    // Round half up by adding half an LSB before the arithmetic shift, then clamp to out_w bits.
    function automatic logic signed [63:0] sat_rnd(
        input logic signed [63:0] x,
        input int                 frac,
        input int                 out_w
    );
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r  = (x + (64'sd1 <<< (frac - 1))) >>> frac;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (r > hi) begin
            return hi;
        end else if (r < lo) begin
            return lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_cmul.sv
// Pipelined complex multiplier: partial products, then sums, then rounded/saturated output.
// Each register level has its own load enable so gaps in the stream leave data untouched.
module fft_cmul #(
    parameter int DATA_W  = 16,
    parameter int TW_W    = 10,
    parameter int TW_FRAC = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     ld_prod,
    input  logic                     ld_sum,
    input  logic                     ld_out,
    input  logic signed [DATA_W-1:0] a_re,
    input  logic signed [DATA_W-1:0] a_im,
    input  logic signed [TW_W-1:0]   b_re,
    input  logic signed [TW_W-1:0]   b_im,
    output logic signed [DATA_W-1:0] y_re,
    output logic signed [DATA_W-1:0] y_im
);
    import fft_pkg::*;

    localparam int PW = DATA_W + TW_W;
    localparam int SW = PW + 1;

    logic signed [PW-1:0] p_rr;
    logic signed [PW-1:0] p_ii;
    logic signed [PW-1:0] p_ri;
    logic signed [PW-1:0] p_ir;
    logic signed [SW-1:0] re_full;
    logic signed [SW-1:0] im_full;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            p_rr <= '0;
            p_ii <= '0;
            p_ri <= '0;
            p_ir <= '0;
        end else if (ld_prod) begin
            p_rr <= PW'(a_re) * PW'(b_re);
            p_ii <= PW'(a_im) * PW'(b_im);
            p_ri <= PW'(a_re) * PW'(b_im);
            p_ir <= PW'(a_im) * PW'(b_re);
        end
    end

    // One extra bit so the difference/sum of two full-width products cannot wrap.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            re_full <= '0;
            im_full <= '0;
        end else if (ld_sum) begin
            re_full <= SW'(p_rr) - SW'(p_ii);
            im_full <= SW'(p_ri) + SW'(p_ir);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            y_re <= '0;
            y_im <= '0;
        end else if (ld_out) begin
            y_re <= DATA_W'(sat_rnd(64'(re_full), TW_FRAC, DATA_W));
            y_im <= DATA_W'(sat_rnd(64'(im_full), TW_FRAC, DATA_W));
        end
    end

endmodule

// File: rtl/fft_tw_mul8.sv
// Twiddle multiplier for 8-sample blocks: drives the twiddle ROM address from the block index
// and multiplies each streamed sample by its twiddle.
module fft_tw_mul8 #(
    parameter int DATA_W  = 16,
    parameter int TW_W    = 10,
    parameter int TW_FRAC = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     din_valid,
    input  logic                     din_start,
    input  logic signed [DATA_W-1:0] din_re,
    input  logic signed [DATA_W-1:0] din_im,
    output logic [2:0]               tw_addr,
    input  logic signed [TW_W-1:0]   tw_re,
    input  logic signed [TW_W-1:0]   tw_im,
    output logic                     dout_valid,
    output logic                     dout_last,
    output logic [2:0]               dout_idx,
    output logic signed [DATA_W-1:0] dout_re,
    output logic signed [DATA_W-1:0] dout_im,
    output logic [7:0]               restart_cnt
);
    import fft_pkg::*;

    logic [2:0] cnt;
    logic [2:0] cur_idx;
    logic       start_now;
    logic       v1;
    logic       v2;
    logic [2:0] idx1;
    logic [2:0] idx2;

    // A qualified start forces index 0 in the same cycle so the ROM already returns twiddle 0.
    always_comb begin
        start_now = din_valid && din_start;
        cur_idx   = start_now ? 3'd0 : cnt;
        tw_addr   = cur_idx;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= 3'd0;
        end else if (din_valid) begin
            cnt <= cur_idx + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            restart_cnt <= 8'd0;
        end else if (start_now && (cnt != 3'd0) && (restart_cnt != 8'hFF)) begin
            restart_cnt <= restart_cnt + 8'd1;
        end
    end

    // Index travels alongside the multiplier's data path.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1         <= 1'b0;
            v2         <= 1'b0;
            idx1       <= 3'd0;
            idx2       <= 3'd0;
            dout_valid <= 1'b0;
            dout_idx   <= 3'd0;
            dout_last  <= 1'b0;
        end else begin
            v1         <= din_valid;
            v2         <= v1;
            dout_valid <= v2;
            if (din_valid) begin
                idx1 <= cur_idx;
            end
            if (v1) begin
                idx2 <= idx1;
            end
            if (v2) begin
                dout_idx  <= idx2;
                dout_last <= (idx2 == 3'd7);
            end
        end
    end

    fft_cmul #(
        .DATA_W (DATA_W),
        .TW_W   (TW_W),
        .TW_FRAC(TW_FRAC)
    ) u_cmul (
        .clk    (clk),
        .rstn   (rstn),
        .ld_prod(din_valid),
        .ld_sum (v1),
        .ld_out (v2),
        .a_re   (din_re),
        .a_im   (din_im),
        .b_re   (tw_re),
        .b_im   (tw_im),
        .y_re   (dout_re),
        .y_im   (dout_im)
    );

endmodule

// File: tb/tb_fft_tw_mul8.sv
// Self-checking bench for fft_tw_mul8: a table-based ROM model plus an arithmetic reference
// model of index sequencing, restart counting and the rounded/saturated complex product.
module tb_fft_tw_mul8;

    typedef struct {
        longint re;
        longint im;
        int     idx;
        logic   last;
        int     due;
    } exp_t;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               din_valid = 1'b0;
    logic               din_start = 1'b0;
    logic signed [15:0] din_re = '0;
    logic signed [15:0] din_im = '0;
    logic [2:0]         tw_addr;
    logic signed [9:0]  tw_re;
    logic signed [9:0]  tw_im;
    logic               dout_valid;
    logic               dout_last;
    logic [2:0]         dout_idx;
    logic signed [15:0] dout_re;
    logic signed [15:0] dout_im;
    logic [7:0]         restart_cnt;

    logic signed [9:0]  rom_re [8];
    logic signed [9:0]  rom_im [8];

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   m_cnt = 0;
    int   m_rst = 0;
    exp_t q[$];
    exp_t last_e;
    exp_t mon_e;

    assign tw_re = rom_re[tw_addr];
    assign tw_im = rom_im[tw_addr];

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    fft_tw_mul8 dut (
        .clk        (clk),
        .rstn       (rstn),
        .din_valid  (din_valid),
        .din_start  (din_start),
        .din_re     (din_re),
        .din_im     (din_im),
        .tw_addr    (tw_addr),
        .tw_re      (tw_re),
        .tw_im      (tw_im),
        .dout_valid (dout_valid),
        .dout_last  (dout_last),
        .dout_idx   (dout_idx),
        .dout_re    (dout_re),
        .dout_im    (dout_im),
        .restart_cnt(restart_cnt)
    );

    task automatic checkOutput(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Round half up (floor of value + 0.5 LSB) and clamp to the 16-bit signed range.
    function automatic longint rnd_sat(input longint v);
        longint t;
        longint r;
        t = v + 128;
        if (t >= 0) r = t / 256;
        else        r = -((-t + 255) / 256);
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    task automatic setRom(input int re, input int im);
        for (int i = 0; i < 8; i++) begin
            rom_re[i] = 10'(re);
            rom_im[i] = 10'(im);
        end
    endtask

    task automatic randRom();
        for (int i = 0; i < 8; i++) begin
            rom_re[i] = 10'($urandom);
            rom_im[i] = 10'($urandom);
        end
    endtask

    function automatic int rnd16();
        return int'($signed(16'($urandom)));
    endfunction

    // Called at posedge+1: drives one cycle of input, predicts the result, advances one clock.
    task automatic applyStimulus(input logic v, input logic s, input int re, input int im);
        int   idx;
        exp_t e;
        din_valid = v;
        din_start = s;
        din_re    = 16'(re);
        din_im    = 16'(im);
        #1;
        idx = (v && s) ? 0 : m_cnt;
        checkOutput("tw_addr", longint'(tw_addr), longint'(idx));
        if (v) begin
            e.re   = rnd_sat(longint'(re) * longint'(rom_re[idx]) - longint'(im) * longint'(rom_im[idx]));
            e.im   = rnd_sat(longint'(re) * longint'(rom_im[idx]) + longint'(im) * longint'(rom_re[idx]));
            e.idx  = idx;
            e.last = (idx == 7);
            e.due  = cyc + 3;
            q.push_back(e);
            if (s && m_cnt != 0 && m_rst < 255) m_rst++;
            m_cnt = (idx + 1) % 8;
        end
        @(posedge clk);
        #1;
        checkOutput("restart_cnt", longint'(restart_cnt), longint'(m_rst));
    endtask

    // Output monitor: every dout_valid must match the oldest prediction on its due cycle,
    // and outputs must hold their last value between pulses.
    always @(negedge clk) begin
        if (rstn) begin
            if (dout_valid) begin
                if (q.size() == 0) begin
                    checkOutput("spurious_valid", 1, 0);
                end else begin
                    mon_e = q.pop_front();
                    checkOutput("latency", longint'(cyc), longint'(mon_e.due));
                    checkOutput("dout_re", longint'(dout_re), mon_e.re);
                    checkOutput("dout_im", longint'(dout_im), mon_e.im);
                    checkOutput("dout_idx", longint'(dout_idx), longint'(mon_e.idx));
                    checkOutput("dout_last", longint'(dout_last), longint'(mon_e.last));
                    last_e = mon_e;
                end
            end else begin
                checkOutput("hold_re", longint'(dout_re), last_e.re);
                checkOutput("hold_im", longint'(dout_im), last_e.im);
                checkOutput("hold_idx", longint'(dout_idx), longint'(last_e.idx));
                checkOutput("hold_last", longint'(dout_last), longint'(last_e.last));
                if (q.size() != 0 && q[0].due <= cyc) begin
                    checkOutput("missing_valid", longint'(cyc), longint'(q[0].due));
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_valid"}, longint'(dout_valid), 0);
        checkOutput({tag, "_re"}, longint'(dout_re), 0);
        checkOutput({tag, "_im"}, longint'(dout_im), 0);
        checkOutput({tag, "_idx"}, longint'(dout_idx), 0);
        checkOutput({tag, "_last"}, longint'(dout_last), 0);
        checkOutput({tag, "_restart"}, longint'(restart_cnt), 0);
        checkOutput({tag, "_tw_addr"}, longint'(tw_addr), 0);
    endtask

    initial begin
        int nv;
        last_e = '{re: 0, im: 0, idx: 0, last: 1'b0, due: 0};
        setRom(256, 0);

        #12;
        checkResetOutputs("reset");
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] unity twiddle block");
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, i == 0, 1000, -500);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 0, 0);

        $display("[TB] directed products");
        setRom(0, -256);
        applyStimulus(1'b1, 1'b1, 300, 200);
        setRom(181, -181);
        applyStimulus(1'b1, 1'b0, 100, 0);
        setRom(-256, 0);
        applyStimulus(1'b1, 1'b0, -32768, 0);
        setRom(256, 256);
        applyStimulus(1'b1, 1'b0, 32767, 32767);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, rnd16(), rnd16());
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 0, 0);

        $display("[TB] gapped stream with wrap");
        randRom();
        nv = 0;
        while (nv < 24) begin
            for (int p = 0; p < 5 && nv < 24; p++) begin
                if (p == 0 || p == 3 || p == 4) begin
                    applyStimulus(1'b1, nv == 0, rnd16(), rnd16());
                    nv++;
                end else begin
                    applyStimulus(1'b0, 1'b0, rnd16(), rnd16());
                end
            end
        end

        $display("[TB] early restart");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, i == 0 || i == 4, rnd16(), rnd16());
        applyStimulus(1'b0, 1'b1, rnd16(), rnd16());
        applyStimulus(1'b0, 1'b1, rnd16(), rnd16());
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, rnd16(), rnd16());

        $display("[TB] random stream");
        for (int i = 0; i < 1600; i++) begin
            randRom();
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rnd16(), rnd16());
        end

        $display("[TB] reset mid-block");
        applyStimulus(1'b1, 1'b0, rnd16(), rnd16());
        applyStimulus(1'b1, 1'b0, rnd16(), rnd16());
        din_valid = 1'b0;
        din_start = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        checkResetOutputs("midreset");
        q.delete();
        m_cnt  = 0;
        m_rst  = 0;
        last_e = '{re: 0, im: 0, idx: 0, last: 1'b0, due: 0};
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 0, 0);
        randRom();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, rnd16(), rnd16());
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 0, 0);

        checkOutput("queue_empty", longint'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
